counter_cell_sequencer: RTL and testbench
=========================================

Name: counter_cell_sequencer

Overview:
- Services involuntary counter requests (PINC/MINC style) against the counter cells in erasable RAM by stealing memory cycles from the Core.
- Latches per-counter increment/decrement requests and raises stall_req to the Core. After the Core acknowledges, it owns the RAM ports and performs a read-modify-write in ones'-complement arithmetic.
- Signals overflow per counter.
- Sits beside Core; its RAM outputs are muxed onto the RAM ports by ram_own.

Parameters:
- NUM_COUNTERS, 8, number of counter cells serviced (1..16).
- BASE_ADDR, 11'o24, RAM address of counter 0; counter i lives at BASE_ADDR+i.

Ports:
- clock  input  1  system clock.
- rst_l  input  1  asynchronous, active-low reset.
- inc_req  input  NUM_COUNTERS  one-cycle pulse: request +1 on counter i.
- dec_req  input  NUM_COUNTERS  one-cycle pulse: request -1 on counter i.
- core_ack  input  1  Core is stalled with no RAM write in flight; level.
- ram_read_data  input  15  RAM read data, valid the cycle after address.
- stall_req  output  1  request Core stall.
- ram_own  output  1  sequencer drives RAM ports this cycle.
- ram_read_address  output  11  counter read address.
- ram_write_address  output  11  counter write address.
- ram_write_data  output  15  updated counter value.
- ram_write_en  output  1  RAM write strobe.
- overflow_pulse  output  NUM_COUNTERS  one-cycle pulse on counter overflow.
- busy  output  1  state != IDLE.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - pend_inc and pend_dec cleared.
  - The asynchronous reset also aborts any in-progress RMW; no write is issued.
- Pending capture, every cycle, per counter i:
  - inc_req[i] sets pend_inc[i]; dec_req[i] sets pend_dec[i].
  - If pend_inc[i] and pend_dec[i] are both set after capture, both clear: net zero, no RAM cycle.
  - A request arriving in the same cycle its bit is being cleared by service leaves the bit set (new request wins).
  - A repeat request on an already-set bit is lost unless the optional feature is present.
- Selection:
  - Fixed priority, lowest index first.
  - sel_idx and sel_dir (inc/dec) are captured on entry to READ.
  - The serviced pending bit is cleared at that same edge.
- FSM states: IDLE, WAIT_ACK, READ, MODIFY, WRITE.
- IDLE -> WAIT_ACK when any pending bit is set. stall_req is registered high from this point.
- WAIT_ACK -> READ when core_ack=1; waits indefinitely otherwise.
- READ:
  - ram_own=1; ram_read_address=BASE_ADDR+sel_idx.
  - Always -> MODIFY.
- MODIFY:
  - ram_own=1; capture ram_read_data as v and compute the result r (rules below).
  - Always -> WRITE.
- WRITE:
  - ram_own=1; ram_write_en=1 for exactly one cycle.
  - ram_write_address=BASE_ADDR+sel_idx; ram_write_data=r.
  - overflow_pulse[sel_idx]=1 in this cycle if overflow occurred.
  - Exit: if another bit is pending -> READ, with stall_req held (back-to-back, no re-ack).
  - Otherwise -> IDLE, with stall_req=0 at the next edge.
- Latency from request pulse to write strobe, with core_ack already high: 4 cycles (capture, WAIT_ACK, READ, MODIFY, then WRITE).
- Arithmetic (15-bit ones' complement):
  - INC, v=0o37777: r=0o00000, overflow.
  - INC, v=0o77777 (-0): r=0o00001.
  - INC, otherwise: r=v+1 (mod 2^15).
  - DEC, v=0o40000: r=0o77777 (-0), overflow.
  - DEC, v=0o00000: r=0o77776.
  - DEC, otherwise: r=v-1.
- core_ack dropping mid-RMW is ignored; the Core must hold its stall while stall_req=1.
- Addresses wrap modulo 2^11.

Optional Feature:
- Macro: COUNTER_OVERRUN_EN.
- When defined:
  - Adds output overrun_flag (NUM_COUNTERS) and input overrun_clr (1).
  - overrun_flag[i] is sticky-set when a request arrives on an already-set same-direction pending bit.
  - Cleared by overrun_clr; set wins over clear in the same cycle. Reset 0.
- When undefined: ports absent; repeat requests are silently dropped.

Test Plan:
1. RAM[0o24]=0o00005, inc_req[0] pulse at cycle 0, core_ack=1 -> write 0o00006 to 0o24 with ram_write_en at cycle 4; stall_req low by cycle 5.
2. RAM[0o27]=0o37777, inc_req[3] -> write 0o00000 to 0o27 plus a one-cycle overflow_pulse[3]. Separately, RAM[0o25]=0o00000, dec_req[1] -> 0o77776 with no overflow.
3. inc_req[5] and inc_req[2] in the same cycle -> counter 2 written first, counter 5 written 3 cycles later; stall_req continuously high, one core_ack.
4. inc_req[4] and dec_req[4] in the same cycle -> no stall_req, no RAM write, pending empty.
5. core_ack held 0 for 10 cycles after inc_req[0] -> stall_req high throughout, ram_own=0; RMW proceeds after ack. Separately, rst_l low during MODIFY -> no write, all outputs 0.
6. (COUNTER_OVERRUN_EN) two inc_req[6] pulses before service -> one write of v+1, overrun_flag[6]=1 until overrun_clr.

Source files
------------

// File: rtl/counter_cell_sequencer.sv
// counter_cell_sequencer: services involuntary counter requests (PINC/MINC
// style) against counter cells in erasable RAM. Requests are latched per
// counter, the Core is asked to stall, and once it acknowledges the
// sequencer owns the RAM ports for a read-modify-write in 15-bit ones'
// complement arithmetic, pulsing overflow_pulse on a counter overflow.
// Optional build macro: COUNTER_OVERRUN_EN adds overrun_flag / overrun_clr,
// which record requests lost because their pending bit was already set.
//
// Handshake: stall_req is a registered level raised when work is pending
// and held until the last write of a burst; core_ack is a level that lets
// the first RMW begin. Once an RMW has started it completes regardless of
// core_ack, and back-to-back services reuse the original acknowledge.
module counter_cell_sequencer #(
  parameter int          NUM_COUNTERS = 8,
  parameter logic [10:0] BASE_ADDR    = 11'o24
) (
  input  logic                    clock,
  input  logic                    rst_l,
  input  logic [NUM_COUNTERS-1:0] inc_req,
  input  logic [NUM_COUNTERS-1:0] dec_req,
  input  logic                    core_ack,
  input  logic [14:0]             ram_read_data,
  output logic                    stall_req,
  output logic                    ram_own,
  output logic [10:0]             ram_read_address,
  output logic [10:0]             ram_write_address,
  output logic [14:0]             ram_write_data,
  output logic                    ram_write_en,
  output logic [NUM_COUNTERS-1:0] overflow_pulse,
  output logic                    busy,
`ifdef COUNTER_OVERRUN_EN
  input  logic                    overrun_clr,
  output logic [NUM_COUNTERS-1:0] overrun_flag,
`endif
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_ACK = 3'd1,
    S_READ     = 3'd2,
    S_MODIFY   = 3'd3,
    S_WRITE    = 3'd4
  } state_t;

  state_t                  state, next_state;
  logic [NUM_COUNTERS-1:0] pend_inc, pend_dec, pend_any;
  logic [NUM_COUNTERS-1:0] svc_inc, svc_dec;
  logic [NUM_COUNTERS-1:0] raw_inc, raw_dec, cap_inc, cap_dec;
  logic [3:0]              pick_idx, sel_idx;
  logic                    pick_dir, sel_dir;
  logic                    go_read;
  logic [14:0]             result, r_comb;
  logic                    result_ovf, ovf_comb;
  logic [10:0]             sel_addr;

  assign pend_any = pend_inc | pend_dec;
  assign sel_addr = BASE_ADDR + 11'(sel_idx);

  // Lowest-index pending counter and its direction (inc when pend_inc set).
  always_comb begin
    pick_idx = '0;
    pick_dir = 1'b0;
    for (int i = NUM_COUNTERS - 1; i >= 0; i--) begin
      if (pend_any[i]) begin
        pick_idx = 4'(i);
        pick_dir = pend_inc[i];
      end
    end
  end

  // A new service starts from WAIT_ACK on acknowledge or straight out of WRITE.
  always_comb begin
    go_read = ((state == S_WAIT_ACK) && core_ack && (|pend_any)) ||
              ((state == S_WRITE) && (|pend_any));
  end

  // Pending capture: service clear first, new requests win, then inc/dec cancel.
  always_comb begin
    svc_inc = '0;
    svc_dec = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (go_read && (pick_idx == 4'(i))) begin
        svc_inc[i] = pend_inc[i];
        svc_dec[i] = pend_dec[i];
      end
    end
    raw_inc = (pend_inc & ~svc_inc) | inc_req;
    raw_dec = (pend_dec & ~svc_dec) | dec_req;
    cap_inc = raw_inc & ~(raw_inc & raw_dec);
    cap_dec = raw_dec & ~(raw_inc & raw_dec);
  end

  // Pending bit registers.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      pend_inc <= '0;
      pend_dec <= '0;
    end else begin
      pend_inc <= cap_inc;
      pend_dec <= cap_dec;
    end
  end

  // State register plus the registered stall request.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      state     <= S_IDLE;
      stall_req <= 1'b0;
    end else begin
      state     <= next_state;
      stall_req <= (next_state != S_IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (|(cap_inc | cap_dec)) next_state = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (go_read)                       next_state = S_READ;
        else if (!(|(cap_inc | cap_dec)))  next_state = S_IDLE;
      end
      S_READ:     next_state = S_MODIFY;
      S_MODIFY:   next_state = S_WRITE;
      S_WRITE:    next_state = go_read ? S_READ : S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Capture the serviced counter on entry to READ.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      sel_idx <= '0;
      sel_dir <= 1'b0;
    end else if (go_read) begin
      sel_idx <= pick_idx;
      sel_dir <= pick_dir;
    end
  end

  // Ones' complement +1 / -1 with the +0/-0 and overflow corner cases.
  always_comb begin
    r_comb   = '0;
    ovf_comb = 1'b0;
    if (sel_dir) begin
      if (ram_read_data == 15'o37777) begin
        r_comb   = 15'o00000;
        ovf_comb = 1'b1;
      end else if (ram_read_data == 15'o77777) begin
        r_comb = 15'o00001;
      end else begin
        r_comb = ram_read_data + 15'd1;
      end
    end else begin
      if (ram_read_data == 15'o40000) begin
        r_comb   = 15'o77777;
        ovf_comb = 1'b1;
      end else if (ram_read_data == 15'o00000) begin
        r_comb = 15'o77776;
      end else begin
        r_comb = ram_read_data - 15'd1;
      end
    end
  end

  // Hold the modified value for the WRITE cycle.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      result     <= '0;
      result_ovf <= 1'b0;
    end else if (state == S_MODIFY) begin
      result     <= r_comb;
      result_ovf <= ovf_comb;
    end
  end

  // Output decode from the current state.
  always_comb begin
    busy              = (state != S_IDLE);
    ram_own           = (state == S_READ) || (state == S_MODIFY) || (state == S_WRITE);
    ram_read_address  = (state == S_READ)  ? sel_addr : '0;
    ram_write_address = (state == S_WRITE) ? sel_addr : '0;
    ram_write_data    = (state == S_WRITE) ? result   : '0;
    ram_write_en      = (state == S_WRITE);
    state_dbg         = state;
    overflow_pulse    = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      overflow_pulse[i] = (state == S_WRITE) && result_ovf && (sel_idx == 4'(i));
    end
  end

`ifdef COUNTER_OVERRUN_EN
  logic [NUM_COUNTERS-1:0] ovr_set;
  assign ovr_set = (inc_req & pend_inc & ~svc_inc) | (dec_req & pend_dec & ~svc_dec);

  // Sticky record of lost repeat requests; a set beats a same-cycle clear.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) overrun_flag <= '0;
    else        overrun_flag <= (overrun_flag & ~{NUM_COUNTERS{overrun_clr}}) | ovr_set;
  end
`endif

endmodule

// File: tb/tb_counter_cell_sequencer.sv
// Bench for counter_cell_sequencer: RAM model, cycle-accurate scenarios and
// randomized multi-counter bursts against an integer ones' complement model.
module tb_counter_cell_sequencer;
  localparam int          N    = 8;
  localparam logic [10:0] BASE = 11'o24;
  localparam int          W    = 34;

  logic          clock;
  logic          rst_l;
  logic [N-1:0]  inc_req, dec_req;
  logic          core_ack;
  logic [14:0]   ram_read_data;
  logic          stall_req, ram_own, ram_write_en, busy;
  logic [10:0]   ram_read_address, ram_write_address;
  logic [14:0]   ram_write_data;
  logic [N-1:0]  overflow_pulse;
  logic [2:0]    state_dbg;
`ifdef COUNTER_OVERRUN_EN
  logic          overrun_clr;
  logic [N-1:0]  overrun_flag;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  counter_cell_sequencer #(.NUM_COUNTERS(N), .BASE_ADDR(BASE)) dut (
    .clock(clock),
    .rst_l(rst_l),
    .inc_req(inc_req),
    .dec_req(dec_req),
    .core_ack(core_ack),
    .ram_read_data(ram_read_data),
    .stall_req(stall_req),
    .ram_own(ram_own),
    .ram_read_address(ram_read_address),
    .ram_write_address(ram_write_address),
    .ram_write_data(ram_write_data),
    .ram_write_en(ram_write_en),
    .overflow_pulse(overflow_pulse),
    .busy(busy),
`ifdef COUNTER_OVERRUN_EN
    .overrun_clr(overrun_clr),
    .overrun_flag(overrun_flag),
`endif
    .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // RAM model: one-cycle read latency; bench preload port has priority.
  logic [14:0] ram [0:2047];
  logic        pre_we;
  logic [10:0] pre_addr;
  logic [14:0] pre_data;

  always @(posedge clock) begin
    ram_read_data <= ram[ram_read_address];
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (ram_write_en && ram_own) ram[ram_write_address] <= ram_write_data;
  end

  // Write monitor.
  always @(negedge clock) begin
    if (rst_l && ram_write_en)
      obs_q.push_back({ram_write_address, ram_write_data, overflow_pulse});
  end

  // Reference: decode ones' complement to an integer, step, re-encode.
  function automatic void model_op(input logic [14:0] v, input bit is_inc,
                                   output logic [14:0] r, output bit ovf);
    logic [14:0] mag;
    int val, nv;
    mag = ~v;
    val = v[14] ? -int'(mag) : int'(v);
    nv  = is_inc ? val + 1 : val - 1;
    ovf = 1'b0;
    if (nv > 16383) begin
      ovf = 1'b1; r = 15'o00000;
    end else if (nv < -16383) begin
      ovf = 1'b1; r = 15'o77777;
    end else if (nv == 0) begin
      r = (val < 0) ? 15'o77777 : 15'o00000;
    end else if (nv > 0) begin
      r = 15'(nv);
    end else begin
      mag = 15'(-nv);
      r = ~mag;
    end
  endfunction

  // Driver tasks.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_ram(input logic [10:0] a, input logic [14:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic drive_req(input logic [N-1:0] inc, input logic [N-1:0] dec);
    inc_req = inc;
    dec_req = dec;
    tick();
    inc_req = '0;
    dec_req = '0;
  endtask

  function automatic logic [14:0] pick_value();
    logic [14:0] v;
    case ($urandom_range(0, 5))
      0: v = 15'o37777;
      1: v = 15'o40000;
      2: v = 15'o00000;
      3: v = 15'o77777;
      4: v = 15'o77776;
      default: v = 15'($urandom_range(0, 32767));
    endcase
    return v;
  endfunction

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({stall_req, ram_own, ram_write_en, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000", {stall_req, ram_own, ram_write_en, busy});
    end
    total++;
    if ({ram_read_address, ram_write_address, ram_write_data, overflow_pulse} !== '0) begin
      bad++;
      $display("FAIL reset_data raddr=%o waddr=%o wdata=%o ovf=%b exp=all zero",
               ram_read_address, ram_write_address, ram_write_data, overflow_pulse);
    end
    rst_l = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || stall_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b stall=%b exp=0 0", busy, stall_req);
    end
  endtask

  // One request with core_ack high: write strobe lands exactly 4 cycles later.
  task automatic test_single_op(input int idx, input bit is_inc, input logic [14:0] v);
    logic [14:0] er;
    bit eo;
    logic [10:0] ea;
    logic [N-1:0] onehot;
    ea = BASE + 11'(idx);
    onehot = '0;
    onehot[idx] = 1'b1;
    model_op(v, is_inc, er, eo);
    set_ram(ea, v);
    core_ack = 1'b1;
    drive_req(is_inc ? onehot : '0, is_inc ? '0 : onehot);
    for (int c = 1; c <= 6; c++) begin
      total++;
      if (ram_write_en !== (c == 4)) begin
        bad++;
        $display("FAIL single_we idx=%0d cycle=%0d got=%b exp=%b", idx, c, ram_write_en, (c == 4));
      end
      total++;
      if (stall_req !== (c <= 4)) begin
        bad++;
        $display("FAIL single_stall idx=%0d cycle=%0d got=%b exp=%b", idx, c, stall_req, (c <= 4));
      end
      total++;
      if (ram_own !== (c >= 2 && c <= 4)) begin
        bad++;
        $display("FAIL single_own idx=%0d cycle=%0d got=%b", idx, c, ram_own);
      end
      total++;
      if (overflow_pulse !== ((c == 4 && eo) ? onehot : '0)) begin
        bad++;
        $display("FAIL single_ovf idx=%0d cycle=%0d got=%b exp_ovf=%b", idx, c, overflow_pulse, eo);
      end
      if (c == 2) begin
        total++;
        if (ram_read_address !== ea) begin
          bad++;
          $display("FAIL single_raddr got=%o exp=%o", ram_read_address, ea);
        end
      end
      if (c == 4) begin
        total++;
        if ({ram_write_address, ram_write_data} !== {ea, er}) begin
          bad++;
          $display("FAIL single_write got=%o/%o exp=%o/%o", ram_write_address, ram_write_data, ea, er);
        end
      end
      tick();
    end
    total++;
    if (ram[ea] !== er) begin
      bad++;
      $display("FAIL single_ram addr=%o got=%o exp=%o", ea, ram[ea], er);
    end
  endtask

  // Two counters in one cycle, single ack pulse: lower index first, 3 cycles apart.
  task automatic test_back_to_back();
    logic [14:0] v2, v5, r2, r5;
    bit o2, o5;
    v2 = 15'($urandom_range(1, 100));
    v5 = 15'($urandom_range(200, 300));
    model_op(v2, 1'b1, r2, o2);
    model_op(v5, 1'b1, r5, o5);
    set_ram(BASE + 11'd2, v2);
    set_ram(BASE + 11'd5, v5);
    core_ack = 1'b0;
    drive_req(8'h24, 8'h00);
    total++;
    if (stall_req !== 1'b1 || ram_own !== 1'b0) begin
      bad++;
      $display("FAIL b2b_wait stall=%b own=%b exp=1 0", stall_req, ram_own);
    end
    core_ack = 1'b1;
    tick();
    core_ack = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      total++;
      if (stall_req !== (c <= 7)) begin
        bad++;
        $display("FAIL b2b_stall cycle=%0d got=%b exp=%b", c, stall_req, (c <= 7));
      end
      total++;
      if (ram_write_en !== (c == 4 || c == 7)) begin
        bad++;
        $display("FAIL b2b_we cycle=%0d got=%b", c, ram_write_en);
      end
      if (c == 4) begin
        total++;
        if ({ram_write_address, ram_write_data} !== {BASE + 11'd2, r2}) begin
          bad++;
          $display("FAIL b2b_first got=%o/%o exp=%o/%o", ram_write_address, ram_write_data, BASE + 11'd2, r2);
        end
      end
      if (c == 7) begin
        total++;
        if ({ram_write_address, ram_write_data} !== {BASE + 11'd5, r5}) begin
          bad++;
          $display("FAIL b2b_second got=%o/%o exp=%o/%o", ram_write_address, ram_write_data, BASE + 11'd5, r5);
        end
      end
      tick();
    end
  endtask

  // Opposite requests on one counter in one cycle cancel completely.
  task automatic test_cancel();
    core_ack = 1'b1;
    obs_q.delete();
    drive_req(8'h10, 8'h10);
    for (int c = 1; c <= 6; c++) begin
      total++;
      if ({stall_req, busy, ram_own} !== 3'b000) begin
        bad++;
        $display("FAIL cancel_idle cycle=%0d stall/busy/own=%b exp=000", c, {stall_req, busy, ram_own});
      end
      tick();
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++;
      $display("FAIL cancel_writes got=%0d exp=0", obs_q.size());
    end
  endtask

  // Stall held without ack; RMW proceeds once ack arrives.
  task automatic test_ack_wait();
    logic [14:0] v, er;
    bit eo;
    bit seen;
    v = 15'o12345;
    model_op(v, 1'b1, er, eo);
    set_ram(BASE, v);
    core_ack = 1'b0;
    drive_req(8'h01, 8'h00);
    for (int c = 1; c <= 10; c++) begin
      total++;
      if (stall_req !== 1'b1 || ram_own !== 1'b0) begin
        bad++;
        $display("FAIL ackwait_hold cycle=%0d stall=%b own=%b exp=1 0", c, stall_req, ram_own);
      end
      tick();
    end
    core_ack = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (ram_write_en) begin
        seen = 1'b1;
        total++;
        if ({ram_write_address, ram_write_data} !== {BASE, er}) begin
          bad++;
          $display("FAIL ackwait_write got=%o/%o exp=%o/%o", ram_write_address, ram_write_data, BASE, er);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ackwait_timeout got=no write exp=write");
    end
    repeat (2) tick();
  endtask

  // Asynchronous reset in MODIFY aborts the RMW.
  task automatic test_reset_mid();
    logic [14:0] v;
    v = 15'o00777;
    set_ram(BASE + 11'd4, v);
    core_ack = 1'b1;
    obs_q.delete();
    drive_req(8'h10, 8'h00);
    tick();
    tick();
    total++;
    if (ram_own !== 1'b1 || ram_write_en !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_pre own=%b we=%b exp=1 0", ram_own, ram_write_en);
    end
    #2 rst_l = 1'b0;
    #1;
    total++;
    if ({stall_req, ram_own, ram_write_en, busy, overflow_pulse, ram_read_address,
         ram_write_address, ram_write_data} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs stall=%b own=%b we=%b busy=%b exp=all zero",
               stall_req, ram_own, ram_write_en, busy);
    end
    @(negedge clock);
    rst_l = 1'b1;
    repeat (5) tick();
    total++;
    if (obs_q.size() != 0 || ram[BASE + 11'd4] !== v) begin
      bad++;
      $display("FAIL rstmid_nowrite writes=%0d ram=%o exp=0 %o", obs_q.size(), ram[BASE + 11'd4], v);
    end
    total++;
    if (busy !== 1'b0 || stall_req !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_idle busy=%b stall=%b exp=0 0", busy, stall_req);
    end
  endtask

  // Second pulse on an already-pending bit yields a single increment.
  task automatic test_repeat();
    logic [14:0] v, er;
    bit eo;
    int cyc;
    v = 15'o00100;
    model_op(v, 1'b1, er, eo);
    set_ram(BASE + 11'd6, v);
    core_ack = 1'b0;
`ifdef COUNTER_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    obs_q.delete();
    drive_req(8'h40, 8'h00);
    tick();
    drive_req(8'h40, 8'h00);
`ifdef COUNTER_OVERRUN_EN
    total++;
    if (overrun_flag !== 8'h40) begin
      bad++;
      $display("FAIL overrun_set got=%b exp=%b", overrun_flag, 8'h40);
    end
`endif
    core_ack = 1'b1;
    cyc = 0;
    while ((busy || stall_req) && cyc < 40) begin
      tick();
      cyc++;
    end
    repeat (3) tick();
    total++;
    if (obs_q.size() != 1) begin
      bad++;
      $display("FAIL repeat_count got=%0d exp=1", obs_q.size());
    end
    total++;
    if (ram[BASE + 11'd6] !== er) begin
      bad++;
      $display("FAIL repeat_value got=%o exp=%o", ram[BASE + 11'd6], er);
    end
`ifdef COUNTER_OVERRUN_EN
    total++;
    if (overrun_flag !== 8'h40) begin
      bad++;
      $display("FAIL overrun_sticky got=%b exp=%b", overrun_flag, 8'h40);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    total++;
    if (overrun_flag !== 8'h00) begin
      bad++;
      $display("FAIL overrun_clear got=%b exp=0", overrun_flag);
    end
`endif
  endtask

  // Random bursts of 1-3 distinct counters; writes expected in index order.
  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [N-1:0] inc_m, dec_m, used;
      logic [14:0] v, er;
      logic [14:0] vals [N];
      bit eo;
      int k, idx, delay, cyc;
      used  = '0;
      inc_m = '0;
      dec_m = '0;
      k = $urandom_range(1, 3);
      while ($countones(used) < k) begin
        idx = $urandom_range(0, N - 1);
        if (!used[idx]) begin
          used[idx] = 1'b1;
          if ($urandom_range(0, 1) == 1) inc_m[idx] = 1'b1;
          else dec_m[idx] = 1'b1;
          v = pick_value();
          vals[idx] = v;
          set_ram(BASE + 11'(idx), v);
        end
      end
      exp_q.delete();
      obs_q.delete();
      for (int i = 0; i < N; i++) begin
        if (used[i]) begin
          logic [N-1:0] oh;
          oh = '0;
          model_op(vals[i], inc_m[i], er, eo);
          if (eo) oh[i] = 1'b1;
          exp_q.push_back({BASE + 11'(i), er, oh});
        end
      end
      delay = $urandom_range(0, 4);
      core_ack = (delay == 0);
      drive_req(inc_m, dec_m);
      cyc = 0;
      while ((busy || stall_req) && cyc < 100) begin
        if (cyc >= delay) core_ack = 1'b1;
        tick();
        cyc++;
      end
      total++;
      if (busy || stall_req) begin
        bad++;
        $display("FAIL rand_timeout iter=%0d busy=%b stall=%b", it, busy, stall_req);
      end
      total++;
      if (obs_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL rand_count iter=%0d got=%0d exp=%0d", it, obs_q.size(), exp_q.size());
      end else begin
        for (int j = 0; j < exp_q.size(); j++) begin
          total++;
          if (obs_q[j] !== exp_q[j]) begin
            bad++;
            $display("FAIL rand_write iter=%0d n=%0d got=%h exp=%h", it, j, obs_q[j], exp_q[j]);
          end
        end
      end
    end
  endtask

  initial begin
    inc_req  = '0;
    dec_req  = '0;
    core_ack = 1'b0;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
`ifdef COUNTER_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    test_reset();
    test_single_op(0, 1'b1, 15'o00005);
    test_single_op(3, 1'b1, 15'o37777);
    test_single_op(1, 1'b0, 15'o00000);
    test_single_op(2, 1'b0, 15'o40000);
    test_single_op(7, 1'b1, 15'o77777);
    test_single_op(4, 1'b1, 15'o77776);
    test_back_to_back();
    test_cancel();
    test_ack_wait();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
